// File: rtl/cic_3_interpolator_pkg.sv
// Shared definitions for the CIC filter family (interpolator and decimator).
package cic_pkg;

  // Role of a cic_stage instance: difference against the held sample, or accumulate.
  typedef enum logic {
    STAGE_COMB,
    STAGE_INTEG
  } stage_mode_e;

  // Datapath width for an N-stage interpolator: the DC gain is R**(N-1).
  // The decimator uses width + $clog2(R**N) instead.
  function automatic int cic_out_width(input int width, input int r, input int n);
    return width + $clog2(r ** (n - 1));
  endfunction

endpackage

// File: rtl/cic_3_interpolator_if.sv
// Sample-stream bundle for the CIC interpolator: rate enables, input sample, output.
interface cic_3_interpolator_if #(
  parameter int R     = 5,
  parameter int width = 2
);
  import cic_pkg::*;

  localparam int OW = cic_out_width(width, R, 3);

  logic                    en_in;
  logic                    en_out;
  logic signed [width-1:0] in;
  logic signed [OW-1:0]    out;

  modport master (output en_in, output en_out, output in, input out);
  modport slave  (input en_in, input en_out, input in, output out);

endinterface

// File: rtl/cic_3_interpolator_stage.sv
// One enable-gated CIC register: a comb (y = d_in - previous d_in) or an
// integrator (y = running sum of d_in). All arithmetic wraps at W bits.
module cic_stage
  import cic_pkg::*;
#(
  parameter int          W    = 7,
  parameter stage_mode_e MODE = STAGE_COMB
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic signed [W-1:0] d_in,
  output logic signed [W-1:0] y
);

  logic signed [W-1:0] acc_q, acc_d;

  // Next value of the stage register: hold unless enabled.
  always_comb begin
    // NOTE: default first so every path assigns acc_d; otherwise a latch is inferred.
    acc_d = acc_q;
    if (en) begin
      acc_d = (MODE == STAGE_COMB) ? d_in : acc_q + d_in;
    end
  end

  // Stage register with synchronous clear.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignment for flops so every register samples pre-edge values.
    if (reset) acc_q <= '0;
    else       acc_q <= acc_d;
  end

  // Comb output is combinational from the register; integrator output is the register.
  assign y = (MODE == STAGE_COMB) ? d_in - acc_q : acc_q;

endmodule

// File: rtl/cic_3_interpolator.sv
// Third-order CIC interpolator (M=1): three combs at the en_in rate, zero-stuffing
// by R via a one-shot pending flag, three integrators at the en_out rate.
module cic_3_interpolator
  import cic_pkg::*;
#(
  parameter int R     = 5,
  parameter int width = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  cic_3_interpolator_if.slave  bus
);

  localparam int OW = cic_out_width(width, R, 3);

  logic signed [OW-1:0] x, c1, c2, c3;
  logic signed [OW-1:0] v, i1, i2, i3;
  logic signed [OW-1:0] u_q, u_d;
  logic                 pending_q, pending_d;

  // Sign-extend the low-rate sample into the full datapath width.
  assign x = OW'(bus.in);

  cic_stage #(.W(OW), .MODE(STAGE_COMB)) u_comb0 (
    .clk(clk), .reset(reset), .en(bus.en_in), .d_in(x),  .y(c1));
  cic_stage #(.W(OW), .MODE(STAGE_COMB)) u_comb1 (
    .clk(clk), .reset(reset), .en(bus.en_in), .d_in(c1), .y(c2));
  cic_stage #(.W(OW), .MODE(STAGE_COMB)) u_comb2 (
    .clk(clk), .reset(reset), .en(bus.en_in), .d_in(c2), .y(c3));

  // Upsample register and pending flag: en_in loads and arms (set beats clear),
  // the next en_out consumes the sample once, after which zeros are stuffed.
  always_comb begin
    u_d       = u_q;
    pending_d = pending_q;
    if (bus.en_out) pending_d = 1'b0;
    if (bus.en_in) begin
      u_d       = c3;
      pending_d = 1'b1;
    end
  end

  // Upsample register and pending flag storage.
  always_ff @(posedge clk) begin
    if (reset) begin
      u_q       <= '0;
      pending_q <= 1'b0;
    end else begin
      u_q       <= u_d;
      pending_q <= pending_d;
    end
  end

  // Zero-stuff mux: exactly one non-zero integrator input per en_in.
  assign v = pending_q ? u_q : '0;

  cic_stage #(.W(OW), .MODE(STAGE_INTEG)) u_integ0 (
    .clk(clk), .reset(reset), .en(bus.en_out), .d_in(v),  .y(i1));
  cic_stage #(.W(OW), .MODE(STAGE_INTEG)) u_integ1 (
    .clk(clk), .reset(reset), .en(bus.en_out), .d_in(i1), .y(i2));
  cic_stage #(.W(OW), .MODE(STAGE_INTEG)) u_integ2 (
    .clk(clk), .reset(reset), .en(bus.en_out), .d_in(i2), .y(i3));

  assign bus.out = i3;

endmodule

// File: doc/cic_3_interpolator.md
Name: cic_3_interpolator

Overview:
- Third-order CIC interpolation filter (N=3, M=1). The transmit-direction counterpart of the cic_3_filter decimator.
- Low-rate samples arrive on en_in. Each passes through three combs, is zero-stuffed by R, and goes through three integrators clocked on en_out.
- Used to bring low-rate baseband/audio samples up to the clk-rate path ahead of modulation/DAC stages.
- DC gain is R**2; out equals R**2 * in in steady state.

Parameters:
- R, 5, interpolation ratio (>= 2)
- width, 2, input data width (signed)
- OW (localparam), width + $clog2(R**2), output and internal datapath width

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- en_in  input  1  low-rate clock enable; one pulse per R en_out pulses
- en_out  input  1  high-rate clock enable; tied 1 for full clk rate
- in  input  width  signed low-rate input sample, sampled when en_in=1
- out  output  OW  signed interpolated output, updates on en_out

Behaviour:
- Interface (already decided): one clock, clk; reset is synchronous and active-high, named reset.
- Reset (synchronous, reset=1 at posedge clk):
  - Clear all comb delays d0..d2, the upsample register u, the pending flag and integrators i1..i3.
  - out=0 on the cycle after reset is sampled. Reset overrides en_in/en_out.
  - Reset mid-operation discards all history; there is no partial flush.
- Arithmetic:
  - in is sign-extended to OW. Every stage is OW-bit two's complement and wraps modulo 2**OW.
  - Wrap is legal: the impulse response is non-negative with per-phase sum R**2, so |true out| <= R**2 * 2**(width-1), which fits OW. The final value is therefore exact.
- Comb section, updated only when en_in=1. The comb chain is combinational between registers.
  - c1 = x - d0; c2 = c1 - d1; c3 = c2 - d2
  - d0<=x, d1<=c1, d2<=c2, u<=c3, pending<=1
- Zero-stuffing / integrator section, updated only when en_out=1:
  - v = pending ? u : 0
  - i1<=i1+v, i2<=i2+i1, i3<=i3+i2, pending<=0. out is i3, registered.
  - The comb-to-integrator handoff is exactly one non-zero sample per en_in, followed by zeros.
- Simultaneous events:
  - en_in and en_out in the same cycle: the integrators consume the old u/pending; the new u loads and pending is set (set wins over clear).
  - en_out=0: all integrators and out hold.
  - en_in=0: the comb state holds.
- Latency, with en_out=1 constantly:
  - A sample loaded on en_in at cycle k reaches i1 at k+2, i2 at k+3, and out (i3) at k+4.
  - The first non-zero out for an impulse appears 3 en_out cycles after u loads.
- Protocol violation: more than one en_in between en_out pulses overwrites u and drops a sample. This is undefined use and is not flagged.

Decomposition:
- Package cic_pkg:
  - function cic_out_width(width, R, N) returning width + $clog2(R**(N-1)).
  - Shared with the decimator, which uses width + $clog2(R**N).
- Sub-module cic_stage, parameterised: a single enable-gated accumulate/difference register used three times as a comb and three times as an integrator.
- Top level: sign extension, pending flag, zero-stuff mux.

Test Plan:
- Reset: hold reset 3 cycles with en_in toggling and in=1 -> out=0 throughout and on the first cycle after reset.
- Step: R=5, width=2, en_out=1, en_in every 5th cycle. in=1 for 2*3*R cycles -> out==25; then in=-1 -> out==-25; then in=0 -> out==0.
- Impulse: in=1 for one en_in, then 0 -> consecutive out values 1,3,6,10,15,18,19,18,15,10,6,3,1, then 0. Sum 125.
- Extreme: in=-2 (most negative) held -> steady out==-50, with no wrap visible at the output.
- Gaps: same step as above but en_out low 1 cycle in 3, with en_in every 5th en_out pulse -> out holds during gaps and settles to 25.
- Mid-run reset: during the impulse, assert reset at the 6th output -> out=0 next cycle. A new impulse afterwards reproduces the full coefficient sequence from 1.
